piso_frame_sequencer: RTL and testbench
=======================================

# piso_frame_sequencer

Controller that sequences a parallel-in/serial-out shift register into framed serial transmission. It accepts a parallel word over a valid/ready handshake, parallel-loads it, and shifts it out LSB-first. The data bits are wrapped in a start bit and a stop bit, each bit held for a programmable number of clocks. It sits between a word-producing datapath and a single-wire serial output.

## Interface
- DATA_W, 8, data bits per frame; legal range 1..16.
- DIV, 4, clocks per serial bit; legal range 1..256.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- in_data  input  DATA_W  parallel word to send.
- in_valid  input  1  producer has a word.
- in_ready  output  1  sequencer can accept a word.
- ser_out  output  1  registered serial line; idle high.
- busy  output  1  frame in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- The state machine has four states: IDLE, START, DATA, STOP (plus PARITY when the parity feature is compiled in).
- Internal registers:
  - shift register sh[DATA_W-1:0];
  - bit-period counter div_cnt, 0..DIV-1;
  - bit index bit_cnt, 0..DATA_W-1.
- IDLE:
  - in_ready=1, ser_out=1.
  - On in_valid & in_ready: sh<=in_data, div_cnt<=0, go to START. No other state changes sh by load.
- START: ser_out=0 for DIV cycles. When div_cnt==DIV-1: div_cnt<=0, bit_cnt<=0, go to DATA.
- DATA:
  - ser_out=sh[0].
  - At div_cnt==DIV-1: sh<=sh>>1 with zero fill (never X), bit_cnt<=bit_cnt+1.
  - When bit_cnt==DATA_W-1 at that point, go to STOP (or PARITY).
- STOP: ser_out=1 for DIV cycles. frame_done=1 in the cycle where div_cnt==DIV-1, then go to IDLE.
- in_ready=0 in every state except IDLE. A word presented while busy is held off by the producer, not dropped.
- in_data is ignored without a handshake. Its changes after acceptance do not affect the frame in flight.
- div_cnt wraps DIV-1 -> 0 inside every bit. For DIV=1, every cycle is a bit boundary.
- ser_out is a register driven from next-state/next-sh values, so the bit value on the line changes exactly on bit boundaries, with no glitch.

## Timing
- Reset values (cycle after reset sampled high): state=IDLE, ser_out=1, in_ready=1, busy=0, frame_done=0, sh=0, counters=0.
- Reset mid-frame aborts immediately:
  - the next cycle shows ser_out=1 and busy=0;
  - no frame_done is issued.
- Reset takes priority over a simultaneous handshake. The word is not accepted.
- Handshake at edge T:
  - the start bit appears on ser_out in cycles T+1..T+DIV;
  - data bit i occupies cycles T+1+(1+i)*DIV .. T+(2+i)*DIV;
  - the stop bit follows the last data bit.
- Frame length is (DATA_W+2)*DIV cycles (+DIV with parity). frame_done falls in the final cycle.
- Back-to-back words: IDLE is occupied for at least one cycle between frames. The next start bit begins at the earliest (DATA_W+2)*DIV+2 cycles after the previous handshake.
- busy=1 from T+1 through the frame_done cycle inclusive.

## Configuration
- Macro PISO_SEQ_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting DIV cycles;
  - ser_out = XOR of the accepted word's DATA_W bits (even parity), captured at load;
  - frame length becomes (DATA_W+3)*DIV.
- Undefined: no PARITY state, no parity register; DATA goes directly to STOP.

## Test plan
- Reset then idle: hold reset 2 cycles, release -> ser_out=1, in_ready=1, busy=0, frame_done=0 for 20 idle cycles.
- DATA_W=8, DIV=4, send 0xA5:
  - ser_out reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each held 4 cycles;
  - frame_done pulses once at cycle 40 after the handshake.
- in_valid held high with 0x3C then 0xC3 queued:
  - in_ready low throughout the first frame, second handshake only after frame_done;
  - both frames correct, one IDLE cycle between them.
- Reset asserted at the 3rd data bit of 0xFF -> next cycle ser_out=1, busy=0, no frame_done; a following 0x01 frame is correct.
- DIV=1, DATA_W=1, send 1 -> ser_out sequence 0,1,1 over 3 cycles; frame_done on the 3rd.
- With PISO_SEQ_PARITY_EN, send 0x07 -> parity bit 1 after the data bits; send 0x03 -> parity bit 0; frame length 44 cycles at DIV=4.

Source files
------------

// File: rtl/piso_frame_sequencer.sv
// piso_frame_sequencer
//
// Frames a parallel word for a single-wire serial line. A word accepted over
// the in_valid/in_ready handshake is parallel-loaded into a shift register
// and sent LSB-first: one low start bit, DATA_W data bits, an optional even
// parity bit, then one high stop bit. Every bit is held for DIV clocks.
//
// Optional feature: define PISO_SEQ_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit. The parity bit is the XOR of
// the accepted word and is captured at load.
//
// Parameters:
//   DATA_W  data bits per frame (1..16)
//   DIV     clocks per serial bit (1..256)
//
// Ports:
//   clk         clock, all logic on posedge
//   reset       synchronous, active-high; aborts any frame in flight
//   in_data     parallel word to send
//   in_valid    producer has a word
//   in_ready    sequencer can accept a word (high only in IDLE)
//   ser_out     registered serial line, idle high
//   busy        a frame is in progress
//   frame_done  one-cycle pulse in the last cycle of the stop bit

module piso_frame_sequencer #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  // With a one-clock bit, the first cycle of the stop bit is also its last.
  localparam logic STOP_IS_ONE_CYCLE = (DIV == 1);

`ifdef PISO_SEQ_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] sh;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
`ifdef PISO_SEQ_PARITY_EN
  logic              par;
`endif

  logic [DATA_W-1:0] sh_shift;
  logic [DIV_W-1:0]  div_inc;
  logic              bit_end;

  assign sh_shift = sh >> 1;
  assign div_inc  = div_cnt + DIV_ONE;
  assign bit_end  = (div_cnt == DIV_LAST);

  // Outputs are registered from the next-state / next-sh values, so the line
  // only changes on bit boundaries and never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sh         <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
`ifdef PISO_SEQ_PARITY_EN
      par        <= 1'b0;
`endif
      ser_out    <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh       <= in_data;
`ifdef PISO_SEQ_PARITY_EN
            par      <= ^in_data;
`endif
            div_cnt  <= '0;
            state    <= START;
            ser_out  <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            ser_out  <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            ser_out <= sh[0];
          end else begin
            div_cnt <= div_inc;
          end
        end

        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            sh      <= sh_shift;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt    <= '0;
`ifdef PISO_SEQ_PARITY_EN
              state      <= PARITY;
              ser_out    <= par;
`else
              state      <= STOP;
              ser_out    <= 1'b1;
              frame_done <= STOP_IS_ONE_CYCLE;
`endif
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
              ser_out <= sh_shift[0];
            end
          end else begin
            div_cnt <= div_inc;
          end
        end

`ifdef PISO_SEQ_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            div_cnt    <= '0;
            state      <= STOP;
            ser_out    <= 1'b1;
            frame_done <= STOP_IS_ONE_CYCLE;
          end else begin
            div_cnt <= div_inc;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            div_cnt  <= '0;
            state    <= IDLE;
            ser_out  <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            div_cnt    <= div_inc;
            // Pulse lands in the cycle whose counter reaches the last slot.
            frame_done <= (div_inc == DIV_LAST);
          end
        end

        default: begin
          state    <= IDLE;
          ser_out  <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_frame_sequencer.sv
// Testbench for piso_frame_sequencer: a DATA_W=8/DIV=4 instance and a
// DATA_W=1/DIV=1 instance, checked cycle by cycle against a frame model that
// derives each line bit from its position in the frame.

module tb_piso_frame_sequencer;

  localparam int W  = 8;
  localparam int D  = 4;
`ifdef PISO_SEQ_PARITY_EN
  localparam int P  = 1;
`else
  localparam int P  = 0;
`endif
  localparam int L  = (W + 2 + P) * D;
  localparam int L1 = (1 + 2 + P) * 1;

  logic         clk;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         busy;
  logic         frame_done;

  logic [0:0]   in_data1;
  logic         in_valid1;
  logic         in_ready1;
  logic         ser_out1;
  logic         busy1;
  logic         frame_done1;

  int errors;
  int checks;

  piso_frame_sequencer #(.DATA_W(W), .DIV(D)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .frame_done(frame_done)
  );

  piso_frame_sequencer #(.DATA_W(1), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .ser_out(ser_out1), .busy(busy1), .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level in frame cycle k (1-based) for a word of w bits.
  function automatic logic exp_bit(input logic [15:0] word, input int k,
                                   input int w, input int div, input int par);
    int idx;
    logic [15:0] m;
    idx = (k - 1) / div;
    m = 16'((32'd1 << w) - 1);
    if (idx == 0) return 1'b0;
    if (idx <= w) return word[idx-1];
    if (par != 0 && idx == w + 1) return ^(word & m);
    return 1'b1;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (ser_out !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got ser=%b rdy=%b busy=%b fd=%b want 1 1 0 0",
                 k, ser_out, in_ready, busy, frame_done);
      end
      @(negedge clk);
    end
  endtask

  // Sends one word and checks every cycle of its frame plus the following idle cycle.
  task automatic test_frame(input logic [W-1:0] word);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_ready got %b want 1", in_ready);
    end
    in_data = word; in_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      in_data = W'($urandom);
      checks++;
      if (ser_out !== exp_bit(16'(word), k, W, D, P)) begin
        errors++;
        $display("FAIL ser word=%h cyc=%0d got %b want %b", word, k, ser_out,
                 exp_bit(16'(word), k, W, D, P));
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || frame_done !== (k == L)) begin
        errors++;
        $display("FAIL ctrl word=%h cyc=%0d got busy=%b rdy=%b fd=%b want 1 0 %b",
                 word, k, busy, in_ready, frame_done, (k == L));
      end
    end
    @(negedge clk);
    checks++;
    if (ser_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL post_idle word=%h got ser=%b busy=%b rdy=%b fd=%b want 1 0 1 0",
               word, ser_out, busy, in_ready, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    int kk;
    logic idle;
    in_data = 8'h3C; in_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 2 * L + 2; k++) begin
      @(negedge clk);
      if (k == 1) in_data = 8'hC3;
      if (k == L + 2) in_valid = 1'b0;
      idle = (k == L + 1) || (k == 2 * L + 2);
      w  = (k <= L) ? 8'h3C : 8'hC3;
      kk = (k <= L) ? k : k - L - 1;
      checks++;
      if (idle) begin
        if (ser_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle cyc=%0d got ser=%b busy=%b rdy=%b fd=%b want 1 0 1 0",
                   k, ser_out, busy, in_ready, frame_done);
        end
      end else begin
        if (ser_out !== exp_bit(16'(w), kk, W, D, P) || busy !== 1'b1 ||
            in_ready !== 1'b0 || frame_done !== (kk == L)) begin
          errors++;
          $display("FAIL b2b cyc=%0d got ser=%b busy=%b rdy=%b fd=%b want %b 1 0 %b",
                   k, ser_out, busy, in_ready, frame_done,
                   exp_bit(16'(w), kk, W, D, P), (kk == L));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    in_data = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    // Third data bit starts at frame cycle 1 + 3*D.
    for (int k = 1; k <= 1 + 3 * D; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
    end
    checks++;
    if (ser_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_bit2 got ser=%b busy=%b want 1 1", ser_out, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ser_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort got ser=%b busy=%b rdy=%b fd=%b want 1 0 1 0",
               ser_out, busy, in_ready, frame_done);
    end
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || ser_out !== 1'b1) begin
        errors++;
        $display("FAIL after_abort cyc=%0d got fd=%b busy=%b ser=%b want 0 0 1",
                 k, frame_done, busy, ser_out);
      end
    end
    test_frame(8'h01);
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; in_valid = 1'b1; in_data = W'($urandom);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (busy !== 1'b0 || ser_out !== 1'b1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_prio cyc=%0d got busy=%b ser=%b rdy=%b want 0 1 1",
                 k, busy, ser_out, in_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 6; n++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) @(negedge clk);
      test_frame(W'($urandom));
    end
  endtask

  task automatic test_div1();
    for (int b = 1; b >= 0; b--) begin
      in_data1 = 1'(b); in_valid1 = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= L1; k++) begin
        @(negedge clk);
        if (k == 1) in_valid1 = 1'b0;
        checks++;
        if (ser_out1 !== exp_bit(16'(b), k, 1, 1, P) || busy1 !== 1'b1 ||
            frame_done1 !== (k == L1)) begin
          errors++;
          $display("FAIL div1 b=%0d cyc=%0d got ser=%b busy=%b fd=%b want %b 1 %b",
                   b, k, ser_out1, busy1, frame_done1, exp_bit(16'(b), k, 1, 1, P), (k == L1));
        end
      end
      @(negedge clk);
      checks++;
      if (ser_out1 !== 1'b1 || busy1 !== 1'b0 || in_ready1 !== 1'b1 || frame_done1 !== 1'b0) begin
        errors++;
        $display("FAIL div1_idle b=%0d got ser=%b busy=%b rdy=%b fd=%b want 1 0 1 0",
                 b, ser_out1, busy1, in_ready1, frame_done1);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'h07);
    test_frame(8'h03);
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_priority();
    test_random();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
